// File: rtl/etc_rgb_encoder_hdr.sv
// ETC1 block header encoder: quantizes two subblock base colors, picks
// differential or individual mode and packs block bits [63:32] through a 2-stage pipeline.
module etc_rgb_encoder_hdr #(
  parameter int CNT_W = 16
) (
  input  logic             sclk,
  input  logic             rsrt,
  input  logic             in_rts,
  output logic             in_rtr,
  input  logic [23:0]      baseColor_0,
  input  logic [23:0]      baseColor_1,
  input  logic [2:0]       cw_0,
  input  logic [2:0]       cw_1,
  input  logic             flipped,
  input  logic             force_ind,
  output logic             out_rts,
  input  logic             out_rtr,
  output logic [31:0]      header,
  input  logic             diff_cnt_clr,
  output logic [CNT_W-1:0] diff_cnt
);

  function automatic logic [4:0] quant5(input logic [7:0] c);
    logic [5:0] s;
    s = 6'(({1'b0, c} + 9'd4) >> 3);
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  function automatic logic [3:0] quant4(input logic [7:0] c);
    logic [4:0] s;
    s = 5'(({1'b0, c} + 9'd8) >> 4);
    return s[4] ? 4'd15 : s[3:0];
  endfunction

  logic s1_vld_reg;
  logic s2_vld_reg;
  logic [31:0] header_reg;
  logic [CNT_W-1:0] diff_cnt_reg;

  logic s2_adv;
  logic in_xfer;
  logic out_xfer;

  assign s2_adv   = !s2_vld_reg || out_rtr;
  assign in_rtr   = !s1_vld_reg || !s2_vld_reg || out_rtr;
  assign in_xfer  = in_rts && in_rtr;
  assign out_xfer = s2_vld_reg && out_rtr;

  assign out_rts  = s2_vld_reg;
  assign header   = header_reg;
  assign diff_cnt = diff_cnt_reg;

  // Stage-1 combinational quantization, one lane per channel (0=R, 1=G, 2=B)
  logic [2:0][4:0] q5_0_c;
  logic [2:0][4:0] q5_1_c;
  logic [2:0][3:0] q4_0_c;
  logic [2:0][3:0] q4_1_c;
  logic [2:0][5:0] d_c;
  logic [2:0]      in_range_c;
  logic            diff_mode_c;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_quant
      assign q5_0_c[gi] = quant5(baseColor_0[gi*8 +: 8]);
      assign q5_1_c[gi] = quant5(baseColor_1[gi*8 +: 8]);
      assign q4_0_c[gi] = quant4(baseColor_0[gi*8 +: 8]);
      assign q4_1_c[gi] = quant4(baseColor_1[gi*8 +: 8]);
      assign d_c[gi]    = {1'b0, q5_1_c[gi]} - {1'b0, q5_0_c[gi]};
      // [-4,3] is exactly the set whose top four bits are a pure sign extension
      assign in_range_c[gi] = (d_c[gi][5:2] == 4'b0000) || (d_c[gi][5:2] == 4'b1111);
    end
  endgenerate

  assign diff_mode_c = !force_ind && (&in_range_c);

  // Stage-1 payload registers; only the valid bit needs reset
  logic [2:0][4:0] s1_q5_reg;
  logic [2:0][2:0] s1_d_reg;
  logic [2:0][3:0] s1_q4_0_reg;
  logic [2:0][3:0] s1_q4_1_reg;
  logic [2:0]      s1_cw_0_reg;
  logic [2:0]      s1_cw_1_reg;
  logic            s1_flip_reg;
  logic            s1_diff_reg;

  always_ff @(posedge sclk) begin
    if (in_xfer) begin
      s1_q5_reg   <= q5_0_c;
      s1_d_reg    <= {d_c[2][2:0], d_c[1][2:0], d_c[0][2:0]};
      s1_q4_0_reg <= q4_0_c;
      s1_q4_1_reg <= q4_1_c;
      s1_cw_0_reg <= cw_0;
      s1_cw_1_reg <= cw_1;
      s1_flip_reg <= flipped;
      s1_diff_reg <= diff_mode_c;
    end
  end

  // Stage-2 packing: one byte per channel, R in the top byte
  logic [2:0][7:0] byte_c;
  logic [31:0]     header_next;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_pack
      assign byte_c[gi] = s1_diff_reg ? {s1_q5_reg[gi], s1_d_reg[gi]}
                                      : {s1_q4_0_reg[gi], s1_q4_1_reg[gi]};
    end
  endgenerate

  assign header_next = {byte_c[0], byte_c[1], byte_c[2],
                        s1_cw_0_reg, s1_cw_1_reg, s1_diff_reg, s1_flip_reg};

  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
      header_reg <= '0;
    end else begin
      if (in_xfer)
        s1_vld_reg <= 1'b1;
      else if (s2_adv)
        s1_vld_reg <= 1'b0;
      if (s2_adv) begin
        s2_vld_reg <= s1_vld_reg;
        if (s1_vld_reg)
          header_reg <= header_next;
      end
    end
  end

  // Clear dominates a coincident increment; the count sticks at all-ones
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt)
      diff_cnt_reg <= '0;
    else if (diff_cnt_clr)
      diff_cnt_reg <= '0;
    else if (out_xfer && header_reg[1] && (diff_cnt_reg != {CNT_W{1'b1}}))
      diff_cnt_reg <= diff_cnt_reg + CNT_W'(1);
  end

endmodule

// File: tb/tb_etc_rgb_encoder_hdr.sv
// Bench for etc_rgb_encoder_hdr: arithmetic reference model with a per-cycle
// compare loop, plus directed vectors with hand-computed headers.
module tb_etc_rgb_encoder_hdr;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          sclk = 1'b0;
  logic          rsrt = 1'b1;
  logic          in_rts = 1'b0;
  logic          in_rtr;
  logic [23:0]   baseColor_0 = '0;
  logic [23:0]   baseColor_1 = '0;
  logic [2:0]    cw_0 = '0;
  logic [2:0]    cw_1 = '0;
  logic          flipped = 1'b0;
  logic          force_ind = 1'b0;
  logic          out_rts;
  logic          out_rtr = 1'b0;
  logic [31:0]   header;
  logic          diff_cnt_clr = 1'b0;
  logic [CW-1:0] diff_cnt;

  always #5 sclk = ~sclk;

  etc_rgb_encoder_hdr #(.CNT_W(CW)) dut (
    .sclk(sclk), .rsrt(rsrt), .in_rts(in_rts), .in_rtr(in_rtr),
    .baseColor_0(baseColor_0), .baseColor_1(baseColor_1),
    .cw_0(cw_0), .cw_1(cw_1), .flipped(flipped), .force_ind(force_ind),
    .out_rts(out_rts), .out_rtr(out_rtr), .header(header),
    .diff_cnt_clr(diff_cnt_clr), .diff_cnt(diff_cnt)
  );

  typedef struct packed {
    logic [31:0] hdr;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pops = 0;
  int          model_cnt = 0;
  logic [31:0] last_hdr = '0;
  logic        rand_rtr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_hdr(input logic [23:0] c0, input logic [23:0] c1,
                                            input logic [2:0] w0, input logic [2:0] w1,
                                            input logic f, input logic fi);
    int  a, b, q5a, q5b, q4a, q4b, d;
    int  by[3];
    bit  diff;
    int  q5s[3], ds[3], q4as[3], q4bs[3];
    diff = !fi;
    for (int ch = 0; ch < 3; ch++) begin
      a = int'(c0[8*ch +: 8]);
      b = int'(c1[8*ch +: 8]);
      q5a = (a + 4) / 8;  if (q5a > 31) q5a = 31;
      q5b = (b + 4) / 8;  if (q5b > 31) q5b = 31;
      q4a = (a + 8) / 16; if (q4a > 15) q4a = 15;
      q4b = (b + 8) / 16; if (q4b > 15) q4b = 15;
      d = q5b - q5a;
      if (d < -4 || d > 3) diff = 0;
      q5s[ch] = q5a; ds[ch] = d; q4as[ch] = q4a; q4bs[ch] = q4b;
    end
    for (int ch = 0; ch < 3; ch++)
      by[ch] = diff ? (q5s[ch] * 8 + (ds[ch] & 7)) : (q4as[ch] * 16 + q4bs[ch]);
    return {8'(by[0]), 8'(by[1]), 8'(by[2]), w0, w1, diff, f};
  endfunction

  task automatic monitor();
    logic exp_rts;
    forever begin
      @(negedge sclk);
      cyc++;
      if (rsrt) begin
        chk("rst_out_rts", 32'(out_rts), 32'(0));
        chk("rst_in_rtr", 32'(in_rtr), 32'(1));
        chk("rst_header", header, 32'(0));
        chk("rst_diff_cnt", 32'(diff_cnt), 32'(0));
        q.delete();
        model_cnt = 0;
      end else begin
        exp_rts = 1'b0;
        if (q.size() > 0)
          exp_rts = (q[0].cyc <= cyc - 2);
        chk("in_rtr", 32'(in_rtr), 32'((q.size() < 2) || out_rtr));
        chk("out_rts", 32'(out_rts), 32'(exp_rts));
        if (out_rts && exp_rts)
          chk("header", header, q[0].hdr);
        chk("diff_cnt", 32'(diff_cnt), 32'(model_cnt));
        if (out_rts && out_rtr && q.size() > 0) begin
          last_hdr = header;
          if (q[0].hdr[1] && model_cnt != MAXC) model_cnt++;
          pops++;
          void'(q.pop_front());
        end
        if (diff_cnt_clr) model_cnt = 0;
        if (in_rts && in_rtr)
          q.push_back('{hdr: model_hdr(baseColor_0, baseColor_1, cw_0, cw_1, flipped, force_ind),
                        cyc: cyc});
      end
    end
  endtask

  task automatic send(input logic [23:0] c0, input logic [23:0] c1, input logic [2:0] w0,
                      input logic [2:0] w1, input logic f, input logic fi, output int stalls);
    logic ok;
    stalls = 0;
    baseColor_0 = c0; baseColor_1 = c1; cw_0 = w0; cw_1 = w1;
    flipped = f; force_ind = fi; in_rts = 1'b1;
    forever begin
      @(negedge sclk);
      ok = in_rtr;
      @(posedge sclk);
      #1;
      if (rand_rtr) out_rtr = 1'($urandom_range(0, 1));
      if (ok) break;
      stalls++;
      if (stalls >= 60) begin
        chk("send_timeout", 32'(stalls), 32'(0));
        break;
      end
    end
  endtask

  task automatic idle();
    in_rts = 1'b0;
    baseColor_0 = 24'($urandom); baseColor_1 = 24'($urandom);
    cw_0 = 3'($urandom); cw_1 = 3'($urandom);
    flipped = 1'($urandom); force_ind = 1'($urandom);
  endtask

  task automatic drain(output int n);
    out_rtr = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge sclk);
      #1;
      n++;
    end
    if (n >= 40) chk("drain_timeout", 32'(q.size()), 32'(0));
  endtask

  task automatic stim();
    int st, n, sum;
    int pops0;
    logic [23:0] rc;
    logic [23:0] b_c1[4]  = '{24'h000060, 24'h000098, 24'h0000A0, 24'h000060};
    logic        b_fi[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] b_exp[4] = '{32'h84000002, 32'h83000002, 32'h8A000000, 32'h86000000};

    repeat (3) @(posedge sclk);
    #1;
    chk("init_header", header, 32'(0));
    chk("init_in_rtr", 32'(in_rtr), 32'(1));
    rsrt = 1'b0;
    out_rtr = 1'b1;

    // Differential and individual reference vectors
    send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    chk("first_after_rst_stalls", 32'(st), 32'(0));
    idle(); drain(n);
    chk("diff_hdr", last_hdr, 32'h81402756);
    chk("diff_cnt_1", 32'(diff_cnt), 32'(1));

    send(24'h0000FF, 24'hFF0000, 3'd0, 3'd0, 1'b1, 1'b0, st);
    idle(); drain(n);
    chk("ind_hdr", last_hdr, 32'hF0000F01);
    chk("ind_cnt", 32'(diff_cnt), 32'(1));

    // R-delta boundaries -4, +3, +4 and force_ind
    for (int i = 0; i < 4; i++) begin
      send(24'h000080, b_c1[i], 3'd0, 3'd0, 1'b0, b_fi[i], st);
      idle(); drain(n);
      chk($sformatf("boundary_%0d", i), last_hdr, b_exp[i]);
    end
    chk("boundary_cnt", 32'(diff_cnt), 32'(3));

    // Random backpressure, 8 back-to-back blocks
    pops0 = pops;
    rand_rtr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rc = 24'($urandom);
      send(rc, rc ^ (24'($urandom) & 24'h0F0F0F), 3'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) == 0), st);
    end
    rand_rtr = 1'b0;
    idle(); drain(n);
    chk("bp_count", 32'(pops - pops0), 32'(8));

    // Full throughput with out_rtr held high
    out_rtr = 1'b1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(24'($urandom), 24'($urandom), 3'(i), 3'(7 - i), 1'(i), 1'b0, st);
      sum += st;
    end
    idle(); drain(n);
    chk("tput_stalls", 32'(sum), 32'(0));
    chk("tput_drain", 32'(n), 32'(2));

    // Reset with two blocks in flight
    out_rtr = 1'b0;
    send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    send(24'h0000FF, 24'hFF0000, 3'd1, 3'd1, 1'b1, 1'b0, st);
    idle();
    @(posedge sclk);
    #3;
    rsrt = 1'b1;
    #1;
    chk("async_rst_out_rts", 32'(out_rts), 32'(0));
    chk("async_rst_header", header, 32'(0));
    chk("async_rst_in_rtr", 32'(in_rtr), 32'(1));
    repeat (2) @(posedge sclk);
    #1;
    rsrt = 1'b0;
    out_rtr = 1'b1;
    send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    chk("post_rst_stalls", 32'(st), 32'(0));
    idle(); drain(n);
    chk("post_rst_hdr", last_hdr, 32'h81402756);
    chk("post_rst_cnt", 32'(diff_cnt), 32'(1));

    // Saturation of the differential counter
    for (int i = 0; i < 15; i++)
      send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    idle(); drain(n);
    chk("sat_cnt", 32'(diff_cnt), 32'(MAXC));
    send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    idle(); drain(n);
    chk("sat_hold", 32'(diff_cnt), 32'(MAXC));

    // Clear coincident with a differential output transfer
    out_rtr = 1'b0;
    send(24'h204080, 24'h184088, 3'd2, 3'd5, 1'b0, 1'b0, st);
    idle();
    n = 0;
    do begin
      @(negedge sclk);
      n++;
    end while (!out_rts && n < 10);
    chk("clr_wait_out_rts", 32'(out_rts), 32'(1));
    @(posedge sclk);
    #1;
    out_rtr = 1'b1;
    diff_cnt_clr = 1'b1;
    @(posedge sclk);
    #1;
    diff_cnt_clr = 1'b0;
    chk("clr_coincident", 32'(diff_cnt), 32'(0));
    chk("clr_queue_empty", 32'(q.size()), 32'(0));
    repeat (3) @(posedge sclk);
  endtask

  initial begin
    fork
      monitor();
      stim();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/etc_rgb_encoder_hdr.md
ETC_RGB_ENCODER_HDR -- requirements
Module: etc_rgb_encoder_hdr

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the differential-mode block counter.
REQ-002 SHALL have port sclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rsrt, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_rts, input, 1, upstream data valid.
REQ-005 SHALL have port in_rtr, output, 1, block ready to accept input.
REQ-006 SHALL have port baseColor_0, input, 24, subblock-0 average color; [7:0]=R, [15:8]=G, [23:16]=B.
REQ-007 SHALL have port baseColor_1, input, 24, subblock-1 average color; same channel layout.
REQ-008 SHALL have port cw_0, input, 3, subblock-0 table codeword.
REQ-009 SHALL have port cw_1, input, 3, subblock-1 table codeword.
REQ-010 SHALL have port flipped, input, 1, flip bit.
REQ-011 SHALL have port force_ind, input, 1, forces individual mode when high.
REQ-012 SHALL have port out_rts, output, 1, header valid.
REQ-013 SHALL have port out_rtr, input, 1, downstream ready.
REQ-014 SHALL have port header, output, 32, packed block bits [63:32]; header[31] = block bit 63.
REQ-015 SHALL have port diff_cnt_clr, input, 1, synchronous clear of diff_cnt.
REQ-016 SHALL have port diff_cnt, output, CNT_W, count of emitted differential-mode headers.

Function
REQ-017 SHALL transfer input when in_rts && in_rtr, and output when out_rts && out_rtr.
REQ-018 SHALL be a two-stage pipeline: S1 registers quantized colors, deltas and mode; S2 registers the packed header; latency exactly 2 cycles from input transfer to out_rts with no stall.
REQ-019 SHALL compute in_rtr = !s1_vld || !s2_vld || out_rtr (combinational); S1 advances into S2 when S2 is empty or transferring.
REQ-020 SHALL sustain one header per cycle while out_rtr is high; no transfer lost or duplicated under any out_rtr pattern.
REQ-021 SHALL hold header and out_rts stable while out_rts && !out_rtr.
REQ-022 SHALL quantize each channel q5 = min(31, (c+4)>>3) and q4 = min(15, (c+8)>>4), unsigned 9-bit intermediates.
REQ-023 SHALL compute per-channel d = q5(color1) - q5(color0) as 6-bit signed.
REQ-024 SHALL select differential mode iff force_ind==0 and all three d lie in [-4,3] inclusive; otherwise individual.
REQ-025 Differential packing SHALL be: per channel (R at bits 63:56, G 55:48, B 47:40) 5-bit q5(color0) then 3-bit two's-complement d; bit 33 = 1.
REQ-026 Individual packing SHALL be: per channel q4(color0) in the high nibble, q4(color1) in the low nibble; bit 33 = 0.
REQ-027 SHALL pack cw_0 at bits 39:37, cw_1 at 36:34, flipped at bit 32.
REQ-028 SHALL increment diff_cnt by 1 on each output transfer with bit 33 = 1, saturating at all-ones.
REQ-029 diff_cnt_clr SHALL zero diff_cnt; if coincident with an increment, the result SHALL be 0.
REQ-030 Inputs SHALL be sampled only on input transfer; values while in_rtr is low SHALL be ignored.

Reset
REQ-031 rsrt high SHALL immediately clear s1_vld, s2_vld, out_rts, header, diff_cnt to 0, independent of sclk.
REQ-032 Reset mid-operation SHALL discard all in-flight blocks; in_rtr SHALL be 1 during and after reset.
REQ-033 First input transfer SHALL be possible on the first rising edge after rsrt deasserts.

Verification
REQ-034 Diff: baseColor_0=0x204080, baseColor_1=0x184088 (B,G,R), cw_0=2, cw_1=5, flipped=0 -> header 0x81402756 two cycles later, diff_cnt=1.
REQ-035 Individual: baseColor_0=0x0000FF, baseColor_1=0xFF0000, cw 0/0, flipped=1 -> header 0xF0000F01, diff_cnt unchanged.
REQ-036 Boundary: R deltas of q5 exactly -4 and +3 -> differential; +4 -> individual; same diff-eligible input with force_ind=1 -> bit 33 = 0.
REQ-037 Backpressure: 8 back-to-back inputs, out_rtr random 50% -> 8 headers in order, none dropped/duplicated, header stable while stalled; out_rtr held 1 -> 1 header/cycle.
REQ-038 Reset with 2 blocks in flight -> out_rts 0 immediately, no stale headers after release; diff_cnt at 2^CNT_W-1 plus one diff header -> stays saturated; clr coincident with increment -> 0.
